// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mdio_pkg
// Brief   : Shared state type and Clause-22/45 frame constants for the MDIO master
// Rev     : 1.0  initial release
// ============================================================================
package mdio_pkg;

    typedef enum logic [2:0] {
        S_PHY_RST = 3'd0,
        S_IDLE    = 3'd1,
        S_PRE     = 3'd2,
        S_HDR     = 3'd3,
        S_TA      = 3'd4,
        S_DATA    = 3'd5,
        S_DONE    = 3'd6
    } mdio_state_t;

    localparam logic [1:0] ST_C22          = 2'b01;
    localparam logic [1:0] ST_C45          = 2'b00;

    localparam logic [1:0] OP_C22_WRITE    = 2'b01;
    localparam logic [1:0] OP_C22_READ     = 2'b10;
    localparam logic [1:0] OP_C45_ADDR     = 2'b00;
    localparam logic [1:0] OP_C45_WRITE    = 2'b01;
    localparam logic [1:0] OP_C45_READ     = 2'b11;
    localparam logic [1:0] OP_C45_READ_INC = 2'b10;

    localparam int FRAME_HDR_BITS = 14;

    // Both Clause-45 read flavours have OP[1] set; Clause-22 has a single read code.
    function automatic logic is_read(input logic c45, input logic [1:0] opc);
        return c45 ? opc[1] : (opc == OP_C22_READ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_master_ctrl_clk_gen.sv
`default_nettype none
// ============================================================================
// Module  : mdio_clk_gen
// Brief   : MDC divider; emits one-cycle strobes on the cycle before each MDC edge
// Rev     : 1.0  initial release
// ============================================================================
module mdio_clk_gen #(
    parameter int CLK_DIV = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mdc,
    output logic mdc_rise,
    output logic mdc_fall
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] r_cnt;
    logic          r_mdc;
    logic          w_wrap;

    assign w_wrap   = en && (r_cnt == DW'(CLK_DIV - 1));
    assign mdc_rise = w_wrap && !r_mdc;
    assign mdc_fall = w_wrap &&  r_mdc;
    assign mdc      = r_mdc;

    // Disabling parks MDC low with a fresh count, so every frame starts with a full low phase.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            r_cnt <= '0;
            r_mdc <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_mdc <= !r_mdc;
        end else begin
            r_cnt <= r_cnt + DW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdio_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mdio_master_ctrl
// Brief   : Clause-22/45 MDIO management master with PHY reset sequencing
// Rev     : 1.0  initial release
// ============================================================================
module mdio_master_ctrl
    import mdio_pkg::*;
#(
    parameter int CLK_DIV  = 3,
    parameter int PRE_LEN  = 32,
    parameter int RST_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cl45,
    input  logic [1:0]  op,
    input  logic        pre_sup,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        o_vld,
    output logic        rd_err,
    output logic        eth_mdc,
    inout  wire         eth_mdio,
    output logic        eth_rst_n
);

    localparam int RW = $clog2(RST_HOLD + 1);

    mdio_state_t r_state, w_next_state;
    logic [RW-1:0] r_rst_cnt;
    logic          r_eth_rst_n;
    logic [4:0]    r_bit;
    logic [31:0]   r_sh;
    logic          r_rd;
    logic [15:0]   r_rd_sh;
    logic          r_ta_err;
    logic [15:0]   r_rd_data;
    logic          r_rd_err;
    logic          w_clk_en, w_mdc_rise, w_mdc_fall;
    logic          w_last_bit, w_oe, w_mdio_o;

    mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (w_clk_en),
        .mdc      (eth_mdc),
        .mdc_rise (w_mdc_rise),
        .mdc_fall (w_mdc_fall)
    );

    assign eth_mdio  = w_oe ? w_mdio_o : 1'bz;
    assign cmd_ready = (r_state == S_IDLE);
    assign o_vld     = (r_state == S_DONE);
    assign rd_data   = r_rd_data;
    assign rd_err    = r_rd_err;
    assign eth_rst_n = r_eth_rst_n;

    always_comb begin
        w_next_state = r_state;
        w_last_bit   = 1'b0;
        w_oe         = 1'b0;
        w_mdio_o     = 1'b1;
        w_clk_en     = 1'b0;
        case (r_state)
            S_PHY_RST: if (r_eth_rst_n) w_next_state = S_IDLE;
            S_IDLE:    if (cmd_valid) w_next_state = pre_sup ? S_HDR : S_PRE;
            S_PRE: begin
                w_clk_en   = 1'b1;
                w_oe       = 1'b1;
                w_last_bit = (r_bit == 5'(PRE_LEN - 1));
                if (w_mdc_fall && w_last_bit) w_next_state = S_HDR;
            end
            S_HDR: begin
                w_clk_en   = 1'b1;
                w_oe       = 1'b1;
                w_mdio_o   = r_sh[31];
                w_last_bit = (r_bit == 5'(FRAME_HDR_BITS - 1));
                if (w_mdc_fall && w_last_bit) w_next_state = S_TA;
            end
            S_TA: begin
                w_clk_en   = 1'b1;
                w_oe       = !r_rd;
                w_mdio_o   = r_sh[31];
                w_last_bit = (r_bit == 5'd1);
                if (w_mdc_fall && w_last_bit) w_next_state = S_DATA;
            end
            S_DATA: begin
                w_clk_en   = 1'b1;
                w_oe       = !r_rd;
                w_mdio_o   = r_sh[31];
                w_last_bit = (r_bit == 5'd15);
                if (w_mdc_fall && w_last_bit) w_next_state = S_DONE;
            end
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_PHY_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_PHY_RST;
            r_rst_cnt   <= '0;
            r_eth_rst_n <= 1'b0;
            r_bit       <= '0;
            r_sh        <= '0;
            r_rd        <= 1'b0;
            r_rd_sh     <= '0;
            r_ta_err    <= 1'b0;
            r_rd_data   <= '0;
            r_rd_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_PHY_RST && !r_eth_rst_n) begin
                if (r_rst_cnt == RW'(RST_HOLD - 1)) r_eth_rst_n <= 1'b1;
                else                                 r_rst_cnt   <= r_rst_cnt + RW'(1);
            end
            // TA bits 1,0 ride in the shift register so writes need no special case.
            if (r_state == S_IDLE && cmd_valid) begin
                r_sh  <= {(cl45 ? ST_C45 : ST_C22), op, phy_addr, reg_addr, 2'b10, wr_data};
                r_rd  <= is_read(cl45, op);
                r_bit <= '0;
            end
            if (w_mdc_rise) begin
                if (r_state == S_TA && r_bit == 5'd1) r_ta_err <= eth_mdio;
                if (r_state == S_DATA)                r_rd_sh  <= {r_rd_sh[14:0], eth_mdio};
            end
            if (w_mdc_fall) begin
                r_bit <= w_last_bit ? 5'd0 : r_bit + 5'd1;
                if (r_state != S_PRE) r_sh <= {r_sh[30:0], 1'b0};
                if (r_state == S_DATA && w_last_bit) begin
                    if (r_rd) r_rd_data <= r_rd_sh;
                    r_rd_err <= r_rd && r_ta_err;
                end
            end
        end
    end

endmodule
`default_nettype wire
